// File: rtl/nios_motion_bbox_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | nios_motion_bbox_pkg : shared types, word map and result mux      |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package nios_motion_bbox_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    SEND  = 1'b1
  } state_e;

  localparam int          NUM_WORDS  = 5;
  localparam logic [15:0] NO_MOTION  = 16'hFFFF;
  localparam logic [2:0]  WORD_COUNT = 3'd0;
  localparam logic [2:0]  WORD_XMIN  = 3'd1;
  localparam logic [2:0]  WORD_XMAX  = 3'd2;
  localparam logic [2:0]  WORD_YMIN  = 3'd3;
  localparam logic [2:0]  WORD_YMAX  = 3'd4;
  localparam logic [2:0]  WORD_LAST  = 3'(NUM_WORDS - 1);

  // A frame without motion reports NO_MOTION for every coordinate word.
  function automatic logic [15:0] result_word(
    input logic [2:0]  idx,
    input logic [15:0] count,
    input logic [11:0] xmin,
    input logic [11:0] xmax,
    input logic [11:0] ymin,
    input logic [11:0] ymax
  );
    logic [15:0] w;
    w = count;
    if (idx != WORD_COUNT && count == 16'd0) begin
      w = NO_MOTION;
    end else begin
      case (idx)
        WORD_XMIN: w = {4'd0, xmin};
        WORD_XMAX: w = {4'd0, xmax};
        WORD_YMIN: w = {4'd0, ymin};
        WORD_YMAX: w = {4'd0, ymax};
        default:   w = count;
      endcase
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios_motion_bbox_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | nios_motion_bbox_if : software pixel/ack strobes and result path  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
interface nios_motion_bbox_if;
  logic [7:0]  img1;
  logic [7:0]  img2;
  logic        clk_f_nios;
  logic        rst_f_nios;
  logic        clk2nios;
  logic [15:0] data2nios;

  modport master (
    output img1, img2, clk_f_nios, rst_f_nios,
    input  clk2nios, data2nios
  );

  modport slave (
    input  img1, img2, clk_f_nios, rst_f_nios,
    output clk2nios, data2nios
  );
endinterface
`default_nettype wire

// File: rtl/nios_motion_bbox_sync_edge_det.sv
`default_nettype none
// +------------------------------------------------------------------+
// | nios_motion_bbox_sync_edge_det : N-flop synchroniser, rise pulse  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module nios_motion_bbox_sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   level_dly_q;
  logic                   level_dly_d;

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], async_in};
    level_dly_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      level_dly_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      level_dly_q <= level_dly_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~level_dly_q;

endmodule
`default_nettype wire

// File: rtl/nios_motion_bbox.sv
`default_nettype none
// +------------------------------------------------------------------+
// | nios_motion_bbox : motion threshold, bounding box and result send |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module nios_motion_bbox
  import nios_motion_bbox_pkg::*;
#(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int THRESH      = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  nios_motion_bbox_if.slave bus
);

  localparam logic [11:0] X_LAST   = 12'(IMG_W - 1);
  localparam logic [11:0] Y_LAST   = 12'(IMG_H - 1);
  localparam logic [8:0]  THRESH_V = 9'(THRESH);

  logic stb_level, stb_rise, stb_edge;
  logic frst_level, frst_rise, frst;

  nios_motion_bbox_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_stb_sync (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .async_in (bus.clk_f_nios),
    .level    (stb_level),
    .rise     (stb_rise)
  );

  nios_motion_bbox_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_frst_sync (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .async_in (bus.rst_f_nios),
    .level    (frst_level),
    .rise     (frst_rise)
  );

  // rise always implies level, so these reduce to the pulse and the level.
  assign stb_edge = stb_rise & stb_level;
  assign frst     = frst_level | frst_rise;

  state_e      state_q, state_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [15:0] count_q, count_d;
  logic [11:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [11:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [2:0]  idx_q, idx_d;
  logic        clk2nios_q, clk2nios_d;
  logic [15:0] data2nios_q, data2nios_d;

  logic [8:0]  diff;
  logic        motion;
  logic        last_pixel;

  assign diff = (bus.img1 >= bus.img2) ? ({1'b0, bus.img1} - {1'b0, bus.img2})
                                       : ({1'b0, bus.img2} - {1'b0, bus.img1});
  assign motion     = diff > THRESH_V;
  assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frst) begin
      state_d = ACCUM;
    end else if (stb_edge) begin
      unique case (state_q)
        ACCUM:   if (last_pixel) state_d = SEND;
        SEND:    if (idx_q == WORD_LAST) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    count_d     = count_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymin_d      = ymin_q;
    ymax_d      = ymax_q;
    idx_d       = idx_q;
    clk2nios_d  = clk2nios_q;
    data2nios_d = data2nios_q;

    if (frst || (stb_edge && state_q == SEND && idx_q == WORD_LAST)) begin
      x_d         = 12'd0;
      y_d         = 12'd0;
      count_d     = 16'd0;
      xmin_d      = 12'hFFF;
      xmax_d      = 12'd0;
      ymin_d      = 12'hFFF;
      ymax_d      = 12'd0;
      idx_d       = WORD_COUNT;
      clk2nios_d  = 1'b0;
      data2nios_d = 16'd0;
    end else if (stb_edge && state_q == ACCUM) begin
      if (motion) begin
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        if (x_q < xmin_q) xmin_d = x_q;
        if (x_q > xmax_q) xmax_d = x_q;
        if (y_q < ymin_q) ymin_d = y_q;
        if (y_q > ymax_q) ymax_d = y_q;
      end
      if (x_q == X_LAST) begin
        x_d = 12'd0;
        if (y_q == Y_LAST) begin
          y_d         = 12'd0;
          clk2nios_d  = 1'b1;
          data2nios_d = result_word(WORD_COUNT, count_d, xmin_d, xmax_d, ymin_d, ymax_d);
        end else begin
          y_d = y_q + 12'd1;
        end
      end else begin
        x_d = x_q + 12'd1;
      end
    end else if (stb_edge && state_q == SEND) begin
      idx_d       = idx_q + 3'd1;
      data2nios_d = result_word(idx_d, count_q, xmin_q, xmax_q, ymin_q, ymax_q);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      x_q         <= 12'd0;
      y_q         <= 12'd0;
      count_q     <= 16'd0;
      xmin_q      <= 12'hFFF;
      xmax_q      <= 12'd0;
      ymin_q      <= 12'hFFF;
      ymax_q      <= 12'd0;
      idx_q       <= WORD_COUNT;
      clk2nios_q  <= 1'b0;
      data2nios_q <= 16'd0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      count_q     <= count_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      idx_q       <= idx_d;
      clk2nios_q  <= clk2nios_d;
      data2nios_q <= data2nios_d;
    end
  end

  assign bus.clk2nios  = clk2nios_q;
  assign bus.data2nios = data2nios_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_motion_bbox.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_nios_motion_bbox : randomised frames against a frame model     |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_nios_motion_bbox;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int TH   = 20;
  localparam int SYNC = 2;
  localparam int N    = W * H;
  localparam int HOLD = SYNC + 2;

  typedef struct packed {
    logic        vld;
    logic [15:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   pa[N];
  int   pb[N];

  always #5 clk = ~clk;

  nios_motion_bbox_if bus ();

  nios_motion_bbox #(
    .IMG_W       (W),
    .IMG_H       (H),
    .THRESH      (TH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Frame model: walk pixels in raster order and apply the motion rules directly.
  task automatic push_expect();
    int cnt, xmn, xmx, ymn, ymx, d;
    exp_t e;
    cnt = 0; xmn = 99999; xmx = -1; ymn = 99999; ymx = -1;
    for (int i = 0; i < N; i++) begin
      d = pa[i] - pb[i];
      if (d < 0) d = -d;
      if (d > TH) begin
        cnt++;
        if (i % W < xmn) xmn = i % W;
        if (i % W > xmx) xmx = i % W;
        if (i / W < ymn) ymn = i / W;
        if (i / W > ymx) ymx = i / W;
      end
    end
    e.vld = 1'b1;
    e.data = 16'(cnt); exp_q.push_back(e);
    e.data = (cnt == 0) ? 16'hFFFF : 16'(xmn); exp_q.push_back(e);
    e.data = (cnt == 0) ? 16'hFFFF : 16'(xmx); exp_q.push_back(e);
    e.data = (cnt == 0) ? 16'hFFFF : 16'(ymn); exp_q.push_back(e);
    e.data = (cnt == 0) ? 16'hFFFF : 16'(ymx); exp_q.push_back(e);
    e.vld = 1'b0; e.data = 16'd0; exp_q.push_back(e);
  endtask

  task automatic strobe(input int a, input int b, input bit last);
    @(negedge clk); #2;
    bus.img1 = 8'(a);
    bus.img2 = 8'(b);
    #1 bus.clk_f_nios = 1'b1;
    if (last) begin
      repeat (SYNC) @(posedge clk);
      #1 check("request_before_latency", 32'(bus.clk2nios), 32'd0);
      @(posedge clk);
      #1 check("request_at_latency", 32'(bus.clk2nios), 32'd1);
      repeat (HOLD - SYNC - 1) @(posedge clk);
    end else begin
      repeat (HOLD) @(posedge clk);
    end
    @(negedge clk); #2;
    bus.clk_f_nios = 1'b0;
    repeat (HOLD) @(posedge clk);
  endtask

  task automatic send_frame();
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) push_expect();
      strobe(pa[i], pb[i], i == N - 1);
    end
  endtask

  task automatic ack(input int n);
    for (int i = 0; i < n; i++) strobe(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_equal(input int v);
    for (int i = 0; i < N; i++) begin
      pa[i] = v;
      pb[i] = v;
    end
  endtask

  task automatic fill_random();
    int a, d, m;
    for (int i = 0; i < N; i++) begin
      a = int'($urandom_range(0, 255));
      m = int'($urandom_range(0, 3));
      pa[i] = a;
      if (m == 0) pb[i] = a;
      else if (m == 1) begin
        d = int'($urandom_range(TH - 1, TH + 2));
        pb[i] = (a + d <= 255) ? a + d : a - d;
      end else pb[i] = int'($urandom_range(0, 255));
    end
  endtask

  task automatic pulse_frst();
    @(negedge clk); #2;
    bus.rst_f_nios = 1'b1;
    repeat (HOLD) @(posedge clk);
    @(negedge clk); #2;
    bus.rst_f_nios = 1'b0;
    repeat (HOLD) @(posedge clk);
  endtask

  task automatic full_frame();
    send_frame();
    ack(5);
    drain();
  endtask

  // Monitor: a new word is due on the request rise and a fixed delay after each ack.
  initial begin : monitor
    bit prev_v, prev_s;
    int pend;
    exp_t e;
    prev_v = 1'b0; prev_s = 1'b0; pend = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0; prev_s = 1'b0; pend = 0;
      end else begin
        if (bus.clk2nios && !prev_v) begin
          if (exp_q.size() == 0) check("unexpected_request", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("word0_valid", 32'(bus.clk2nios), 32'(e.vld));
            check("word0_data", 32'(bus.data2nios), 32'(e.data));
          end
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            if (exp_q.size() == 0) check("unexpected_ack_response", 32'd1, 32'd0);
            else begin
              e = exp_q.pop_front();
              check("post_ack_valid", 32'(bus.clk2nios), 32'(e.vld));
              check("post_ack_data", 32'(bus.data2nios), 32'(e.data));
            end
          end
        end
        if (bus.clk2nios && bus.clk_f_nios && !prev_s) pend = SYNC + 2;
        prev_v = bus.clk2nios;
        prev_s = bus.clk_f_nios;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bus.img1 = 8'd0;
    bus.img2 = 8'd0;
    bus.clk_f_nios = 1'b0;
    bus.rst_f_nios = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_clk2nios", 32'(bus.clk2nios), 32'd0);
    check("reset_data2nios", 32'(bus.data2nios), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // No motion: count 0, coordinates FFFF.
    fill_equal(50);
    full_frame();

    // Two motion pixels at (1,0) and (2,2).
    fill_equal(50);
    pa[1] = 100; pb[1] = 70;
    pa[10] = 10; pb[10] = 40;
    full_frame();

    // Threshold boundary and absolute difference.
    fill_equal(50);
    pa[0] = 70; pb[0] = 50;
    pa[5] = 71; pb[5] = 50;
    pa[11] = 0; pb[11] = 255;
    full_frame();

    // Abort SEND with frame restart after word1 is acked.
    fill_random();
    pa[6] = 200; pb[6] = 0;
    send_frame();
    ack(2);
    @(negedge clk); #2;
    bus.rst_f_nios = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    #1 check("frst_abort_clk2nios", 32'(bus.clk2nios), 32'd0);
    check("frst_abort_data2nios", 32'(bus.data2nios), 32'd0);
    exp_q.delete();
    repeat (HOLD) @(posedge clk);
    @(negedge clk); #2;
    bus.rst_f_nios = 1'b0;
    repeat (HOLD) @(posedge clk);
    fill_equal(30);
    pa[3] = 90; pb[3] = 10;
    full_frame();

    // Frame restart after 5 accumulated pixels.
    for (int i = 0; i < 5; i++) strobe(200, 0, 1'b0);
    pulse_frst();
    fill_equal(80);
    pa[8] = 0; pb[8] = 120;
    for (int i = 0; i < N - 1; i++) strobe(pa[i], pb[i], 1'b0);
    check("no_request_after_11_pixels", 32'(bus.clk2nios), 32'd0);
    push_expect();
    strobe(pa[N-1], pb[N-1], 1'b1);
    ack(5);
    drain();

    // Randomised frames.
    for (int f = 0; f < 4; f++) begin
      fill_random();
      full_frame();
    end

    // Asynchronous reset mid-SEND.
    fill_random();
    pa[2] = 255; pb[2] = 0;
    send_frame();
    ack(1);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1 check("async_reset_clk2nios", 32'(bus.clk2nios), 32'd0);
    check("async_reset_data2nios", 32'(bus.data2nios), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    fill_random();
    full_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
